// File: rtl/conv_batch_scheduler.sv
// Convolution batch scheduler: per accepted audio trigger, issues one read per impulse
// line, accumulates the returned line sums and emits one scaled output sample.
// Build option: define CONV_SATURATE_EN to clamp the output instead of wrapping it.
module conv_batch_scheduler #(
    parameter int IMPULSE_LENGTH = 48000,
    parameter int BATCH_SIZE     = 8,
    parameter int READ_LATENCY   = 2,
    parameter int OUT_SHIFT      = 15
) (
    input  logic               audio_clk,
    input  logic               rst_in,
    input  logic               audio_trigger,
    input  logic               impulse_in_memory_complete,
    output logic               line_req,
    output logic [15:0]        line_addr,
    output logic [15:0]        hist_base,
    input  logic signed [31:0] convolved_line,
    output logic signed [15:0] convolved_audio,
    output logic               audio_valid_out,
    output logic               busy,
    output logic               overrun
);
    localparam int          NUM_LINES = IMPULSE_LENGTH / BATCH_SIZE;
    localparam logic [15:0] LAST_LINE = 16'(NUM_LINES - 1);
    localparam logic [15:0] LAST_HIST = 16'(IMPULSE_LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    state_t                  state_r;
    logic signed [47:0]      acc_r;
    logic [READ_LATENCY-1:0] vpipe_r;

    logic                    trig_s;
    logic                    start_s;
    logic                    drop_s;
    logic                    ret_valid_s;
    logic signed [47:0]      line_ext_s;

    // Arithmetic scaling of the accumulator down to the 16-bit output sample.
    function automatic logic signed [15:0] scale_acc(input logic signed [47:0] acc_v);
        logic signed [47:0] shifted_v;
        shifted_v = acc_v >>> OUT_SHIFT;
`ifdef CONV_SATURATE_EN
        if (shifted_v > 48'sd32767) begin
            return 16'sh7FFF;
        end else if (shifted_v < -48'sd32768) begin
            return 16'sh8000;
        end else begin
            return $signed(shifted_v[15:0]);
        end
`else
        return $signed(shifted_v[15:0]);
`endif
    endfunction

    // Trigger qualification and return-strobe decode.
    always_comb begin
        trig_s      = audio_trigger & impulse_in_memory_complete;
        start_s     = trig_s & (state_r == IDLE);
        drop_s      = trig_s & (state_r != IDLE);
        ret_valid_s = vpipe_r[READ_LATENCY-1];
        line_ext_s  = {{16{convolved_line[31]}}, convolved_line};
    end

    // Delays each line_req by the memory latency so returns line up with their strobe.
    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            vpipe_r <= {READ_LATENCY{1'b0}};
        end else begin
            vpipe_r[0] <= line_req;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vpipe_r[i] <= vpipe_r[i-1];
            end
        end
    end

    // Accumulator: cleared when a sample starts, then sums every tracked return.
    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            acc_r <= 48'sd0;
        end else if (start_s) begin
            acc_r <= 48'sd0;
        end else if (ret_valid_s) begin
            acc_r <= acc_r + line_ext_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    // Sequencing FSM with all control outputs registered.
    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            state_r         <= IDLE;
            line_req        <= 1'b0;
            line_addr       <= 16'd0;
            hist_base       <= 16'd0;
            convolved_audio <= 16'sd0;
            audio_valid_out <= 1'b0;
            busy            <= 1'b0;
            overrun         <= 1'b0;
        end else begin
            audio_valid_out <= 1'b0;
            if (drop_s) begin
                overrun <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        state_r   <= ISSUE;
                        busy      <= 1'b1;
                        line_req  <= 1'b1;
                        line_addr <= 16'd0;
                        hist_base <= (hist_base == LAST_HIST) ? 16'd0 : hist_base + 16'd1;
                    end
                end
                ISSUE: begin
                    if (line_addr == LAST_LINE) begin
                        line_req <= 1'b0;
                        state_r  <= DRAIN;
                    end else begin
                        line_addr <= line_addr + 16'd1;
                    end
                end
                DRAIN: begin
                    // Pipeline empty means the final return was summed on the previous edge.
                    if (vpipe_r == {READ_LATENCY{1'b0}}) begin
                        state_r         <= OUTPUT;
                        audio_valid_out <= 1'b1;
                        convolved_audio <= scale_acc(acc_r);
                    end
                end
                OUTPUT: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r  <= IDLE;
                    line_req <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_conv_batch_scheduler.sv
// Directed bench for conv_batch_scheduler with a cycle-level reference model and a
// simple latency-matched line memory responder.
module tb_conv_batch_scheduler;
    localparam int IL  = 16;
    localparam int BS  = 4;
    localparam int RL  = 2;
    localparam int OS  = 0;
    localparam int NL  = IL / BS;
    localparam int LAT = NL + RL + 1;

    logic               clk = 1'b0;
    logic               rst_in;
    logic               audio_trigger;
    logic               impulse_in_memory_complete;
    logic               line_req;
    logic [15:0]        line_addr;
    logic [15:0]        hist_base;
    logic signed [31:0] convolved_line;
    logic signed [15:0] convolved_audio;
    logic               audio_valid_out;
    logic               busy;
    logic               overrun;

    logic signed [31:0] line_data [NL];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    conv_batch_scheduler #(
        .IMPULSE_LENGTH(IL),
        .BATCH_SIZE    (BS),
        .READ_LATENCY  (RL),
        .OUT_SHIFT     (OS)
    ) dut (
        .audio_clk                 (clk),
        .rst_in                    (rst_in),
        .audio_trigger             (audio_trigger),
        .impulse_in_memory_complete(impulse_in_memory_complete),
        .line_req                  (line_req),
        .line_addr                 (line_addr),
        .hist_base                 (hist_base),
        .convolved_line            (convolved_line),
        .convolved_audio           (convolved_audio),
        .audio_valid_out           (audio_valid_out),
        .busy                      (busy),
        .overrun                   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected output sample: sum of all line values, shifted, then wrapped or clamped.
    function automatic logic signed [15:0] model_result();
        longint s;
        s = 0;
        for (int i = 0; i < NL; i++) s += longint'(line_data[i]);
        s = s >>> OS;
`ifdef CONV_SATURATE_EN
        if (s > 32767) return 16'sh7FFF;
        if (s < -32768) return 16'sh8000;
`endif
        return 16'(s);
    endfunction

    // Line memory: returns line_data[addr] exactly RL cycles after each request, junk otherwise.
    logic        req_d  [RL+1];
    logic [15:0] addr_d [RL+1];
    initial begin
        convolved_line = 32'sd0;
        for (int k = 0; k <= RL; k++) begin
            req_d[k]  = 1'b0;
            addr_d[k] = 16'd0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int k = RL; k > 0; k--) begin
                req_d[k]  = req_d[k-1];
                addr_d[k] = addr_d[k-1];
            end
            req_d[0]  = line_req;
            addr_d[0] = line_addr;
            convolved_line = req_d[RL] ? line_data[int'(addr_d[RL]) % NL] : 32'sh5A5A0101;
        end
    end

    // Reference model: tracks the accepted trigger edge and derives every output from it.
    bit                 m_active = 1'b0;
    int                 m_t      = 0;
    int                 m_hist   = 0;
    int                 m_addr   = 0;
    bit                 m_over   = 1'b0;
    logic signed [15:0] m_out    = 16'sd0;
    bit                 in_issue, exp_valid, exp_busy;
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst_in) begin
                m_active = 1'b0;
                m_hist   = 0;
                m_over   = 1'b0;
                m_out    = 16'sd0;
                m_addr   = 0;
            end else if (audio_trigger && impulse_in_memory_complete) begin
                if (m_active && cyc <= m_t + LAT + 1) begin
                    m_over = 1'b1;
                end else begin
                    m_active = 1'b1;
                    m_t      = cyc;
                    m_hist   = (m_hist + 1) % IL;
                end
            end
            @(negedge clk);
            in_issue  = m_active && cyc >= m_t && cyc < m_t + NL;
            exp_valid = m_active && cyc == m_t + LAT;
            exp_busy  = m_active && cyc >= m_t && cyc <= m_t + LAT;
            if (in_issue) m_addr = cyc - m_t;
            if (exp_valid) m_out = model_result();
            check("cmp_line_req", line_req, in_issue);
            check("cmp_line_addr", line_addr, m_addr);
            check("cmp_hist_base", hist_base, m_hist);
            check("cmp_valid", audio_valid_out, exp_valid);
            check("cmp_audio", convolved_audio, m_out);
            check("cmp_busy", busy, exp_busy);
            check("cmp_overrun", overrun, m_over);
        end
    end

    task automatic set_lines(input int a, input int b, input int c, input int d);
        line_data[0] = a;
        line_data[1] = b;
        line_data[2] = c;
        line_data[3] = d;
    endtask

    // Called at a falling edge; the trigger is sampled by the next rising edge.
    task automatic pulse();
        audio_trigger = 1'b1;
        @(negedge clk);
        audio_trigger = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int seen_at);
        seen_at = -1;
        for (int i = 0; i < limit; i++) begin
            if (audio_valid_out === 1'b1) begin
                seen_at = cyc;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (seen_at < 0) begin
            bad++;
            $display("FAIL valid_timeout: got no strobe, expected one within %0d cycles (cycle %0d)", limit, cyc);
        end
    endtask

    initial begin
        int t0, seen, cnt;
        logic signed [15:0] sat_exp;
        rst_in                     = 1'b1;
        audio_trigger              = 1'b0;
        impulse_in_memory_complete = 1'b0;
        set_lines(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_line_req", line_req, 0);
        check("rst_line_addr", line_addr, 0);
        check("rst_hist_base", hist_base, 0);
        check("rst_audio", convolved_audio, 0);
        check("rst_valid", audio_valid_out, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        rst_in = 1'b0;
        impulse_in_memory_complete = 1'b1;

        // Basic sample: 10+20+30+40, strobe 7 cycles after the trigger edge.
        set_lines(10, 20, 30, 40);
        @(negedge clk);
        pulse();
        t0 = cyc;
        for (int i = 0; i < NL; i++) begin
            check("t1_req", line_req, 1);
            check("t1_addr", line_addr, i);
            @(negedge clk);
        end
        check("t1_req_low", line_req, 0);
        wait_valid(20, seen);
        check("t1_latency", seen - t0, 7);
        check("t1_result", convolved_audio, 100);
        check("t1_hist", hist_base, 1);
        @(negedge clk);
        check("t1_single_strobe", audio_valid_out, 0);
        check("t1_hold", convolved_audio, 100);
        repeat (3) @(negedge clk);

        // Trigger two cycles into a sample is dropped and flagged.
        set_lines(1, 2, 3, 4);
        pulse();
        @(negedge clk);
        pulse();
        check("t2_hist", hist_base, 2);
        wait_valid(20, seen);
        check("t2_result", convolved_audio, 10);
        check("t2_overrun", overrun, 1);
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (audio_valid_out) cnt++;
        end
        check("t2_extra_strobes", cnt, 0);
        check("t2_hist_after", hist_base, 2);

        // Large line sums; memory-complete drops mid-sample without aborting it.
`ifdef CONV_SATURATE_EN
        sat_exp = 16'sh7FFF;
`else
        sat_exp = 16'sh0000;
`endif
        set_lines(32'sh7FFF0000, 32'sh7FFF0000, 32'sh7FFF0000, 32'sh7FFF0000);
        pulse();
        @(negedge clk);
        impulse_in_memory_complete = 1'b0;
        wait_valid(20, seen);
        check("t3_result", convolved_audio, sat_exp);
        impulse_in_memory_complete = 1'b1;
        repeat (3) @(negedge clk);
        check("t3_overrun_sticky", overrun, 1);

        // After reset, a trigger without a loaded impulse does nothing.
        rst_in = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
        impulse_in_memory_complete = 1'b0;
        pulse();
        cnt = 0;
        repeat (15) begin
            if (line_req || audio_valid_out) cnt++;
            @(negedge clk);
        end
        check("t4_activity", cnt, 0);
        check("t4_hist", hist_base, 0);
        check("t4_overrun", overrun, 0);

        // Sixteen accepted samples walk hist_base 1..15 then wrap to 0.
        impulse_in_memory_complete = 1'b1;
        set_lines(1, 1, 1, 1);
        for (int k = 0; k < IL; k++) begin
            pulse();
            check("t5_hist", hist_base, (k + 1) % IL);
            wait_valid(20, seen);
            check("t5_result", convolved_audio, 4);
            repeat (2) @(negedge clk);
        end

        // Reset during DRAIN: in-flight returns and overrun are discarded.
        set_lines(5, 6, 7, 8);
        pulse();
        @(negedge clk);
        pulse();
        check("t6_overrun_pre", overrun, 1);
        repeat (2) @(negedge clk);
        check("t6_drain_busy", busy, 1);
        check("t6_drain_req", line_req, 0);
        rst_in = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
        check("t6_overrun_rst", overrun, 0);
        check("t6_busy_rst", busy, 0);
        set_lines(1, 2, 3, 4);
        pulse();
        wait_valid(20, seen);
        check("t6_result", convolved_audio, 10);
        check("t6_overrun", overrun, 0);
        check("t6_hist", hist_base, 1);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
